// File: rtl/apb_master_arb.sv
// Two-requester APB master. It arbitrates between requesters 0 and 1 with a fair
// last-grant rule and runs IDLE/SETUP/ACCESS transfers with a wait-state timeout.
module apb_master_arb #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        wr_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        elig;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    ack_d      = 2'b00;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    // The requester being acked this cycle must not be re-granted on its stale request.
    elig       = req_i & ~ack_q;

    case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          gnt_d      = (elig == 2'b11) ? ~last_gnt_q : elig[1];
          last_gnt_d = gnt_d;
          pwrite_d   = wr_i[gnt_d];
          paddr_d    = gnt_d ? addr1_i : addr0_i;
          pwdata_d   = gnt_d ? wdata1_i : wdata0_i;
          psel_d     = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = pslverr;
          if (!pwrite_q) rdata_d = prdata;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          state_d      = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            ack_d[gnt_q] = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
            psel_d       = 1'b0;
            penable_d    = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      to_cnt_q   <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: table of single transfers plus hand-written
// back-to-back, timeout and mid-ACCESS reset sequences, with an ack scoreboard.
module tb_apb_master_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [1:0]  wr_i = 2'b00;
  logic [11:0] addr0_i = '0, addr1_i = '0;
  logic [31:0] wdata0_i = '0, wdata1_i = '0;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master_arb #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_i(wr_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Slave model: ready after slv_waits ACCESS cycles, or never when stuck.
  int          slv_waits = 0;
  bit          slv_stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  bit          slv_err = 1'b0;
  int          acc_cnt = 0;

  always begin
    @(posedge clk); #2;
    if (psel && penable) begin
      pready = !slv_stuck && (acc_cnt >= slv_waits);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
    pslverr = pready && slv_err;
    prdata  = slv_rdata;
  end

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  always begin
    @(posedge clk); #3;
    if (ack_o != 2'b00) begin
      $display("ack=%b err=%b rdata=0x%08h", ack_o, err_o, rdata_o);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'b0, ack_o}, 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("ack_o", {30'b0, ack_o}, {30'b0, e.ack});
        chk("err_o", {31'b0, err_o}, {31'b0, e.err});
        chk("rdata_o", rdata_o, e.rdata);
      end
    end
  end

  typedef struct {
    logic        rq;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        stuck;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_access;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic run_xfer(input vec_t v);
    int cyc = 0, n_setup = 0, n_access = 0, bad_cmd = 0;
    bit got = 1'b0;
    logic psel_at_ack = 1'b1;
    slv_waits = v.waits; slv_stuck = v.stuck; slv_rdata = v.prdata; slv_err = v.slverr;
    wr_i     = v.rq ? {v.wr, ~v.wr} : {~v.wr, v.wr};
    addr0_i  = v.rq ? 12'hEEE : v.addr;
    addr1_i  = v.rq ? v.addr : 12'hEEE;
    wdata0_i = v.rq ? 32'hBAD0BAD0 : v.wdata;
    wdata1_i = v.rq ? v.wdata : 32'hBAD0BAD0;
    sb.push_back('{ack: (v.rq ? 2'b10 : 2'b01), err: v.exp_err, rdata: v.exp_rdata});
    req_i = v.rq ? 2'b10 : 2'b01;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (psel && !penable) n_setup++;
      if (psel && penable) n_access++;
      if (psel && (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata)) bad_cmd++;
      if (ack_o != 2'b00) begin
        got = 1'b1;
        psel_at_ack = psel;
      end
    end
    req_i = 2'b00;
    chk("ack_seen", {31'b0, got}, 32'd1);
    chk("latency", cyc, v.exp_access + 2);
    chk("setup_cycles", n_setup, 1);
    chk("access_cycles", n_access, v.exp_access);
    chk("cmd_stable", bad_cmd, 0);
    chk("psel_low_at_ack", {31'b0, psel_at_ack}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nack, n_bad;
    vecs[0] = '{1'b0, 1'b1, 12'h010, 32'hA5A50001, 2, 1'b0, 32'h0,        1'b0, 3,  1'b0, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 12'h004, 32'h0,        0, 1'b0, 32'h00001234, 1'b0, 1,  1'b0, 32'h00001234};
    vecs[2] = '{1'b0, 1'b0, 12'h008, 32'h0,        1, 1'b0, 32'hDEADBEEF, 1'b0, 2,  1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 12'h00C, 32'h11112222, 0, 1'b0, 32'h0,        1'b1, 1,  1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 12'h014, 32'h33334444, 0, 1'b0, 32'h0,        1'b0, 1,  1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 12'h018, 32'h0,        0, 1'b1, 32'h99999999, 1'b0, 15, 1'b1, 32'h00000000};
    vecs[6] = '{1'b1, 1'b0, 12'hFFC, 32'h0,        3, 1'b0, 32'h0000ABCD, 1'b1, 4,  1'b1, 32'h0000ABCD};
    vecs[7] = '{1'b1, 1'b0, 12'h000, 32'h0,        0, 1'b0, 32'h5A5A5A5A, 1'b0, 1,  1'b0, 32'h5A5A5A5A};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_ack", {30'b0, ack_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_paddr", {20'b0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;

    // Both requesting from reset: grants 0,1,0,1 with each SETUP in the ack cycle's successor
    slv_waits = 0; slv_stuck = 1'b0; slv_rdata = 32'h0; slv_err = 1'b0;
    wr_i = 2'b11; addr0_i = 12'h100; addr1_i = 12'h200;
    wdata0_i = 32'h00000100; wdata1_i = 32'h00000200;
    for (int i = 0; i < 4; i++)
      sb.push_back('{ack: ((i % 2 == 0) ? 2'b01 : 2'b10), err: 1'b0, rdata: 32'h0});
    req_i = 2'b11;
    cyc = 0; nack = 0;
    while (nack < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (psel && !penable)
        chk("b2b_setup_addr", {20'b0, paddr}, (nack % 2 == 0) ? 32'h100 : 32'h200);
      if (ack_o != 2'b00) begin
        nack++;
        chk("b2b_ack_cycle", cyc, 3 * nack);
        if (nack == 4) req_i = 2'b00;
      end
    end
    chk("b2b_acks", nack, 4);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Reset while in ACCESS: outputs clear at once and the transfer is never acked
    slv_stuck = 1'b1; slv_waits = 0; slv_err = 1'b0;
    wr_i = 2'b00; addr0_i = 12'h020; addr1_i = 12'h024;
    req_i = 2'b01;
    cyc = 0;
    while (!(psel && penable) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_access", {31'b0, psel && penable}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_psel", {31'b0, psel}, 32'd0);
    chk("async_penable", {31'b0, penable}, 32'd0);
    chk("async_ack", {30'b0, ack_o}, 32'd0);
    chk("async_paddr", {20'b0, paddr}, 32'd0);
    chk("async_rdata", rdata_o, 32'd0);
    req_i = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_o != 2'b00 || psel) n_bad++;
    end
    chk("no_ack_after_reset", n_bad, 0);

    slv_stuck = 1'b0; slv_rdata = 32'h00000077;
    addr0_i = 12'h030; addr1_i = 12'h040;
    sb.push_back('{ack: 2'b01, err: 1'b0, rdata: 32'h00000077});
    req_i = 2'b11;
    cyc = 0; nack = 0;
    while (nack < 1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (psel && !penable) chk("post_rst_grant_addr", {20'b0, paddr}, 32'h030);
      if (ack_o != 2'b00) begin
        nack++;
        req_i = 2'b00;
        chk("post_rst_ack_cycle", cyc, 3);
      end
    end
    chk("post_rst_acks", nack, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
